pes_cc_packer: RTL and testbench

- Downstream stage of the pes_cc base-delta cache-line compressor.
- Accepts one compressed line per transaction: a 256-bit LSB-aligned payload plus a 3-bit encoding ID.
- Serialises the line into 64-bit beats with byte-keep and last markers, using valid/ready handshakes on both sides.
- Output feeds the compressed-cache write port. Only the significant bytes of each line are sent.

---
 rtl/pes_cc_pkg.sv | 66 ++++++
 rtl/pes_cc_len_decode.sv | 18 +
 rtl/pes_cc_packer.sv | 142 ++++++++++++++
 tb/tb_pes_cc_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pes_cc_pkg.sv
// Shared constants for the pes_cc base-delta compressor family:
// encoding IDs, per-encoding payload lengths and beat counts.
package pes_cc_pkg;

  localparam int CHUNK_BITS = 64;

  localparam logic [2:0] ENC_UNCOMP = 3'd0;
  localparam logic [2:0] ENC_B8D1   = 3'd1;
  localparam logic [2:0] ENC_B8D2   = 3'd2;
  localparam logic [2:0] ENC_B8D4   = 3'd3;
  localparam logic [2:0] ENC_B4D1   = 3'd4;
  localparam logic [2:0] ENC_B4D2   = 3'd5;
  localparam logic [2:0] ENC_B2D1   = 3'd6;
  localparam logic [2:0] ENC_RSVD   = 3'd7;

  localparam int LEN_UNCOMP = 256;
  localparam int LEN_B8D1   = 96;
  localparam int LEN_B8D2   = 128;
  localparam int LEN_B8D4   = 192;
  localparam int LEN_B4D1   = 96;
  localparam int LEN_B4D2   = 160;
  localparam int LEN_B2D1   = 144;

  localparam logic [2:0] BEATS_UNCOMP = 3'((LEN_UNCOMP + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B8D1   = 3'((LEN_B8D1   + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B8D2   = 3'((LEN_B8D2   + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B8D4   = 3'((LEN_B8D4   + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B4D1   = 3'((LEN_B4D1   + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B4D2   = 3'((LEN_B4D2   + CHUNK_BITS - 1) / CHUNK_BITS);
  localparam logic [2:0] BEATS_B2D1   = 3'((LEN_B2D1   + CHUNK_BITS - 1) / CHUNK_BITS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Number of 64-bit beats a line of this encoding occupies (0 for reserved).
  function automatic logic [2:0] beat_count(input logic [2:0] enc);
    case (enc)
      ENC_UNCOMP: beat_count = BEATS_UNCOMP;
      ENC_B8D1:   beat_count = BEATS_B8D1;
      ENC_B8D2:   beat_count = BEATS_B8D2;
      ENC_B8D4:   beat_count = BEATS_B8D4;
      ENC_B4D1:   beat_count = BEATS_B4D1;
      ENC_B4D2:   beat_count = BEATS_B4D2;
      ENC_B2D1:   beat_count = BEATS_B2D1;
      default:    beat_count = 3'd0;
    endcase
  endfunction

  // Byte enables of the final beat: the significant bytes left over
  // once all full 64-bit chunks of the payload are accounted for.
  function automatic logic [7:0] last_keep(input logic [2:0] enc);
    case (enc)
      ENC_UNCOMP: last_keep = 8'hFF;
      ENC_B8D1:   last_keep = 8'h0F;
      ENC_B8D2:   last_keep = 8'hFF;
      ENC_B8D4:   last_keep = 8'hFF;
      ENC_B4D1:   last_keep = 8'h0F;
      ENC_B4D2:   last_keep = 8'h0F;
      ENC_B2D1:   last_keep = 8'h03;
      default:    last_keep = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pes_cc_len_decode.sv
// Combinational encoding decoder: beat count, last-beat keep and validity.
module pes_cc_len_decode
  import pes_cc_pkg::*;
(
  input  logic [2:0] enc,
  output logic [2:0] beats,
  output logic [7:0] last_keep_mask,
  output logic       valid
);

  // Table lookup; reserved encoding reports invalid with zero beats.
  always_comb begin
    beats          = beat_count(enc);
    last_keep_mask = last_keep(enc);
    valid          = (enc != ENC_RSVD);
  end

endmodule

// File: rtl/pes_cc_packer.sv
// Serialises one compressed cache line into 64-bit beats with keep/last,
// sending only the significant bytes, with back-to-back line support.
module pes_cc_packer
  import pes_cc_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_enc,
  input  logic [LINE_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEAT_W-1:0]     out_data,
  output logic [BEAT_W/8-1:0]   out_keep,
  output logic                  out_last,
  output logic [2:0]            out_enc,
  output logic                  err_enc,
  output logic [15:0]           line_cnt
);

  localparam int KEEP_W = BEAT_W / 8;

  state_t              state, state_nxt;
  logic [LINE_W-1:0]   data_q;
  logic [2:0]          enc_q;
  logic [2:0]          total_q;
  logic [KEEP_W-1:0]   keep_q;
  logic [1:0]          idx_q;
  logic                err_q;
  logic [15:0]         cnt_q;

  logic [2:0]          dec_beats;
  logic [KEEP_W-1:0]   dec_keep;
  logic                dec_valid;

  logic                load, err_set, idx_inc, cnt_inc;
  logic                send, beat_last;
  logic [BEAT_W-1:0]   beat;
  logic [KEEP_W-1:0]   keep;

  pes_cc_len_decode u_len_decode (
    .enc            (in_enc),
    .beats          (dec_beats),
    .last_keep_mask (dec_keep),
    .valid          (dec_valid)
  );

  assign send      = (state == ST_SEND);
  assign beat_last = ({1'b0, idx_q} == (total_q - 3'd1));

  // Next state and handshake control; a last-beat handshake reopens the input.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    idx_inc   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (dec_valid) begin
            load      = 1'b1;
            state_nxt = ST_SEND;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (beat_last) begin
            cnt_inc   = 1'b1;
            in_ready  = 1'b1;
            state_nxt = ST_IDLE;
            if (in_valid) begin
              if (dec_valid) begin
                load      = 1'b1;
                state_nxt = ST_SEND;
              end else begin
                err_set = 1'b1;
              end
            end
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, beat index, sticky error, line counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx_q <= 2'd0;
      err_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      state <= state_nxt;
      if (load)         idx_q <= 2'd0;
      else if (idx_inc) idx_q <= idx_q + 2'd1;
      if (err_set)      err_q <= 1'b1;
      if (cnt_inc)      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Line payload and its decoded attributes, captured on acceptance.
  always_ff @(posedge clock) begin
    if (load) begin
      data_q  <= in_data;
      enc_q   <= in_enc;
      total_q <= dec_beats;
      keep_q  <= dec_keep;
    end
  end

  // Beat mux and byte masking; everything is forced to zero outside SEND.
  always_comb begin
    beat     = data_q[idx_q*BEAT_W +: BEAT_W];
    keep     = '0;
    out_data = '0;
    if (send) keep = beat_last ? keep_q : '1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep[i]) out_data[8*i +: 8] = beat[8*i +: 8];
    end
  end

  assign out_valid = send;
  assign out_keep  = keep;
  assign out_last  = send & beat_last;
  assign out_enc   = send ? enc_q : 3'd0;
  assign err_enc   = err_q;
  assign line_cnt  = cnt_q;

endmodule

// File: tb/tb_pes_cc_packer.sv
// Directed bench for pes_cc_packer with hand-computed beat expectations.
module tb_pes_cc_packer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_enc;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [7:0]   out_keep;
  logic         out_last;
  logic [2:0]   out_enc;
  logic         err_enc;
  logic [15:0]  line_cnt;

  int npass = 0;
  int nchk  = 0;

  logic [63:0] ed [7];
  logic [15:0] exp_cnt;

  pes_cc_packer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_enc    (in_enc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_enc   (out_enc),
    .err_enc   (err_enc),
    .line_cnt  (line_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic [2:0] e);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_data"},  out_data,       d);
    chk({tag, "_keep"},  64'(out_keep),  64'(k));
    chk({tag, "_last"},  64'(out_last),  64'(l));
    chk({tag, "_enc"},   64'(out_enc),   64'(e));
  endtask

  initial begin
    in_valid  = 1'b0;
    in_enc    = 3'd0;
    in_data   = '0;
    out_ready = 1'b1;

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_data",  out_data,       64'h0);
    chk("rst_keep",  64'(out_keep),  64'h0);
    chk("rst_last",  64'(out_last),  64'h0);
    chk("rst_enc",   64'(out_enc),   64'h0);
    chk("rst_err",   64'(err_enc),   64'h0);
    chk("rst_cnt",   64'(line_cnt),  64'h0);
    step();
    step();
    reset = 1'b0;
    chk("rst_rel_ready", 64'(in_ready), 64'(1'b1));

    // enc=1: 96-bit payload, garbage above must be masked off
    in_data  = {{5{32'hDEADBEEF}}, 96'h00224466_00000000000000FF};
    in_enc   = 3'd1;
    in_valid = 1'b1;
    chk("t1_ready_idle", 64'(in_ready), 64'(1'b1));
    step();
    in_valid = 1'b0;
    chk_beat("t1b0", 64'h00000000000000FF, 8'hFF, 1'b0, 3'd1);
    chk("t1_ready_busy", 64'(in_ready), 64'(1'b0));
    step();
    chk_beat("t1b1", 64'h0000000000224466, 8'h0F, 1'b1, 3'd1);
    chk("t1_ready_last", 64'(in_ready), 64'(1'b1));
    step();
    chk("t1_idle_valid", 64'(out_valid), 64'(1'b0));
    chk("t1_cnt", 64'(line_cnt), 64'd1);

    // enc=6 with sink stalls on beat 1
    in_data  = {16'hBEEF, {3{32'hDEADBEEF}}, 16'h0085, 128'h0123456789ABCDEF_FEDCBA9876543210};
    in_enc   = 3'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t2b0", 64'hFEDCBA9876543210, 8'hFF, 1'b0, 3'd6);
    step();
    out_ready = 1'b0;
    chk_beat("t2b1", 64'h0123456789ABCDEF, 8'hFF, 1'b0, 3'd6);
    step();
    chk_beat("t2b1_stall1", 64'h0123456789ABCDEF, 8'hFF, 1'b0, 3'd6);
    chk("t2_ready_stall", 64'(in_ready), 64'(1'b0));
    step();
    chk_beat("t2b1_stall2", 64'h0123456789ABCDEF, 8'hFF, 1'b0, 3'd6);
    out_ready = 1'b1;
    step();
    chk_beat("t2b2", 64'h0000000000000085, 8'h03, 1'b1, 3'd6);
    step();
    chk("t2_idle_valid", 64'(out_valid), 64'(1'b0));
    chk("t2_cnt", 64'(line_cnt), 64'd2);

    // enc=0 followed back-to-back by enc=3
    ed[0] = 64'h1111000000000001; ed[1] = 64'h2222000000000002;
    ed[2] = 64'h3333000000000003; ed[3] = 64'h4444000000000004;
    ed[4] = 64'hB0B0B0B0B0B0B0B0; ed[5] = 64'hB1B1B1B1B1B1B1B1;
    ed[6] = 64'hB2B2B2B2B2B2B2B2;
    in_data  = {ed[3], ed[2], ed[1], ed[0]};
    in_enc   = 3'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        in_data  = {64'hFFFFFFFFFFFFFFFF, ed[6], ed[5], ed[4]};
        in_enc   = 3'd3;
        in_valid = 1'b1;
        chk("t3_ready_busy", 64'(in_ready), 64'(1'b0));
      end
      if (k == 3) chk("t3_ready_last", 64'(in_ready), 64'(1'b1));
      chk_beat($sformatf("t3b%0d", k), ed[k], 8'hFF, (k == 3 || k == 6), (k < 4) ? 3'd0 : 3'd3);
      step();
      if (k == 3) in_valid = 1'b0;
    end
    chk("t3_idle_valid", 64'(out_valid), 64'(1'b0));
    chk("t3_cnt", 64'(line_cnt), 64'd4);

    // reserved encoding is dropped and flagged
    in_data  = {4{64'h7777777777777777}};
    in_enc   = 3'd7;
    in_valid = 1'b1;
    chk("t4_ready_idle", 64'(in_ready), 64'(1'b1));
    step();
    in_valid = 1'b0;
    chk("t4_no_valid", 64'(out_valid), 64'(1'b0));
    chk("t4_err", 64'(err_enc), 64'(1'b1));
    step();
    chk("t4_no_valid2", 64'(out_valid), 64'(1'b0));
    chk("t4_err_sticky", 64'(err_enc), 64'(1'b1));
    chk("t4_cnt_same", 64'(line_cnt), 64'd4);
    in_data  = {128'hAAAAAAAAAAAAAAAA_AAAAAAAAAAAAAAAA, 64'hC1C2C3C4C5C6C7C8, 64'hC0C0C0C0C0C0C0C0};
    in_enc   = 3'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t4b0", 64'hC0C0C0C0C0C0C0C0, 8'hFF, 1'b0, 3'd2);
    step();
    chk_beat("t4b1", 64'hC1C2C3C4C5C6C7C8, 8'hFF, 1'b1, 3'd2);
    step();
    chk("t4_cnt", 64'(line_cnt), 64'd5);
    chk("t4_err_kept", 64'(err_enc), 64'(1'b1));

    // reset in the middle of an enc=5 line
    in_data  = {96'h999999999999999999999999, 32'hE2E2E2E2, 64'hE1E1E1E1E1E1E1E1, 64'hE0E0E0E0E0E0E0E0};
    in_enc   = 3'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t5b0", 64'hE0E0E0E0E0E0E0E0, 8'hFF, 1'b0, 3'd5);
    step();
    chk_beat("t5b1", 64'hE1E1E1E1E1E1E1E1, 8'hFF, 1'b0, 3'd5);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'(1'b0));
    chk("t5_rst_data",  out_data,       64'h0);
    chk("t5_rst_keep",  64'(out_keep),  64'h0);
    chk("t5_rst_last",  64'(out_last),  64'h0);
    chk("t5_rst_enc",   64'(out_enc),   64'h0);
    chk("t5_rst_cnt",   64'(line_cnt),  64'h0);
    chk("t5_rst_err",   64'(err_enc),   64'h0);
    step();
    reset = 1'b0;
    chk("t5_rel_ready", 64'(in_ready), 64'(1'b1));
    chk("t5_rel_valid", 64'(out_valid), 64'(1'b0));
    in_data  = {{5{32'h55555555}}, 32'h13579BDF, 64'h2468ACE02468ACE0};
    in_enc   = 3'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t5n_b0", 64'h2468ACE02468ACE0, 8'hFF, 1'b0, 3'd4);
    step();
    chk_beat("t5n_b1", 64'h0000000013579BDF, 8'h0F, 1'b1, 3'd4);
    step();
    chk("t5n_idle", 64'(out_valid), 64'(1'b0));
    chk("t5n_cnt", 64'(line_cnt), 64'd1);

    // line counter wrap: preload near the top to keep the run short
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    chk("t6_preload", 64'(line_cnt), 64'hFFFE);
    in_data  = {128'h0, 64'h0000000000000B0B, 64'h0000000000000A0A};
    in_enc   = 3'd2;
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      step();
      exp_cnt = 16'hFFFF + 16'(i);
      chk($sformatf("t6_cnt%0d", i), 64'(line_cnt), 64'(exp_cnt));
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
